// File: rtl/lfsr_coord_gen.sv
// Pseudo-random (x, y) grid coordinate generator: free-running Fibonacci LFSR plus a
// rejection-sampling draw FSM that probes board occupancy. Define LFSR_SEED_MIX_EN to mix seed_in into the feedback.
module lfsr_coord_gen #(
  parameter int                WIDTH      = 10,
  parameter logic [WIDTH-1:0]  TAPS       = 10'h240,
  parameter logic [WIDTH-1:0]  RESET_SEED = 10'h00F,
  parameter int                X_MAX      = 40,
  parameter int                Y_MAX      = 30,
  parameter int                SHIFTS     = 10,
  parameter int                MAX_TRIES  = 15,
  localparam int               XW         = $clog2(X_MAX),
  localparam int               YW         = $clog2(Y_MAX)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             seed_in,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [XW-1:0]    x_out,
  output logic [YW-1:0]    y_out,
  output logic             fail,
  output logic [XW-1:0]    probe_x,
  output logic [YW-1:0]    probe_y,
  input  logic             probe_occupied,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int CW = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
  localparam int TW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  // Bounds may equal 2^XW / 2^YW, so compare with one extra bit.
  localparam logic [XW:0] X_LIM = (XW+1)'(X_MAX);
  localparam logic [YW:0] Y_LIM = (YW+1)'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_X,
    S_SHIFT_Y,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [CW-1:0]    r_cnt;
  logic [TW-1:0]    r_tries;
  logic             r_busy;
  logic             r_valid;
  logic             r_fail;
  logic [XW-1:0]    r_x_out;
  logic [YW-1:0]    r_y_out;
  logic [XW-1:0]    r_probe_x;
  logic [YW-1:0]    r_probe_y;

  logic             w_fb;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [XW-1:0]    w_cand_x;
  logic [YW-1:0]    w_cand_y;
  logic             w_x_ok;
  logic             w_y_ok;
  logic             w_cnt_last;
  logic             w_tries_left;

`ifdef LFSR_SEED_MIX_EN
  always_comb begin
    w_fb        = (^(r_lfsr & TAPS)) ^ seed_in;
    w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
    if (w_lfsr_next == '0)
      w_lfsr_next = RESET_SEED;
  end
`else
  logic w_unused_seed;
  assign w_unused_seed = seed_in;

  always_comb begin
    w_fb        = ^(r_lfsr & TAPS);
    w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
    if (w_lfsr_next == '0)
      w_lfsr_next = RESET_SEED;
  end
`endif

  assign w_cand_x     = r_lfsr[XW-1:0];
  assign w_cand_y     = r_lfsr[YW-1:0];
  assign w_x_ok       = {1'b0, w_cand_x} < X_LIM;
  assign w_y_ok       = {1'b0, w_cand_y} < Y_LIM;
  assign w_cnt_last   = (r_cnt == CW'(SHIFTS - 1));
  assign w_tries_left = (r_tries < TW'(MAX_TRIES));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= RESET_SEED;
      r_cnt     <= '0;
      r_tries   <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_fail    <= 1'b0;
      r_x_out   <= '0;
      r_y_out   <= '0;
      r_probe_x <= '0;
      r_probe_y <= '0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= S_SHIFT_X;
            r_cnt   <= '0;
            r_tries <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT_X: begin
          // Out-of-range samples restart the shift window without costing a try.
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_x_ok) begin
              r_probe_x <= w_cand_x;
              r_state   <= S_SHIFT_Y;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SHIFT_Y: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_y_ok) begin
              r_probe_y <= w_cand_y;
              r_state   <= S_CHECK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CHECK: begin
          if (probe_occupied && w_tries_left) begin
            r_tries <= r_tries + TW'(1);
            r_cnt   <= '0;
            r_state <= S_SHIFT_X;
          end else begin
            r_fail  <= probe_occupied;
            r_x_out <= r_probe_x;
            r_y_out <= r_probe_y;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign valid      = r_valid;
  assign fail       = r_fail;
  assign x_out      = r_x_out;
  assign y_out      = r_y_out;
  assign probe_x    = r_probe_x;
  assign probe_y    = r_probe_y;
  assign lfsr_state = r_lfsr;

endmodule

// File: tb/tb_lfsr_coord_gen.sv
// Self-checking bench for lfsr_coord_gen: default instance plus a wide-bound, MAX_TRIES=3 instance,
// with an independent LFSR model and a latency-predicting scoreboard.
module tb_lfsr_coord_gen;

  localparam int SH = 10;
  localparam logic [9:0] TAPS = 10'h240;
  localparam logic [9:0] SEED = 10'h00F;

  typedef struct {
    int v_cyc;
    int chk_cyc;
    int x;
    int y;
    bit f;
  } exp_t;

  typedef struct {
    logic       seed;
    logic [9:0] lfsr;
  } vec_t;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic seed_in = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  int   occ_mode0 = 0;
  int   occ_mode1 = 0;

  logic       busy0, valid0, fail0, probe_occ0;
  logic [5:0] x_out0, probe_x0;
  logic [4:0] y_out0, probe_y0;
  logic [9:0] lfsr_state0;

  logic       busy1, valid1, fail1, probe_occ1;
  logic [9:0] x_out1, probe_x1;
  logic [9:0] y_out1, probe_y1;
  logic [9:0] lfsr_state1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [9:0] m_lfsr;
  exp_t q0[$];
  exp_t q1[$];

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [9:0] lfsr_step(input logic [9:0] s);
    logic [9:0] n;
    n = {s[8:0], ^(s & TAPS)};
    if (n == 10'd0) n = SEED;
    return n;
  endfunction

  always @(posedge Clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  // Toy board: mode 0 empty, mode 1 full, mode 2 a fixed sparse pattern.
  function automatic bit board(input int mode, input int x, input int y);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ((x * 7 + y * 3) % 4) == 0;
  endfunction

  assign probe_occ0 = board(occ_mode0, int'(probe_x0), int'(probe_y0));
  assign probe_occ1 = board(occ_mode1, int'(probe_x1), int'(probe_y1));

  lfsr_coord_gen dut0 (
    .Clk(Clk), .reset(reset), .seed_in(seed_in), .req(req0),
    .busy(busy0), .valid(valid0), .x_out(x_out0), .y_out(y_out0), .fail(fail0),
    .probe_x(probe_x0), .probe_y(probe_y0), .probe_occupied(probe_occ0),
    .lfsr_state(lfsr_state0)
  );

  lfsr_coord_gen #(.X_MAX(1024), .Y_MAX(1024), .MAX_TRIES(3)) dut1 (
    .Clk(Clk), .reset(reset), .seed_in(seed_in), .req(req1),
    .busy(busy1), .valid(valid1), .x_out(x_out1), .y_out(y_out1), .fail(fail1),
    .probe_x(probe_x1), .probe_y(probe_y1), .probe_occupied(probe_occ1),
    .lfsr_state(lfsr_state1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, expv, expv, cyc);
    end
  endtask

  // Predict latency (edges after E0 until valid) and result from the LFSR value seen before E0.
  function automatic void predict(input logic [9:0] lpre, input int xmax, input int ymax,
                                  input int xw, input int yw, input int mt, input int mode,
                                  output int lat, output int px, output int py, output bit pf);
    logic [9:0] v;
    int k, tries;
    v = lpre; k = 0; tries = 0; lat = 0; px = 0; py = 0; pf = 1'b0;
    while (1) begin
      do begin
        for (int i = 0; i < SH; i++) v = lfsr_step(v);
        k += SH;
        px = int'(v) % (1 << xw);
      end while (px >= xmax);
      do begin
        for (int i = 0; i < SH; i++) v = lfsr_step(v);
        k += SH;
        py = int'(v) % (1 << yw);
      end while (py >= ymax);
      if (!board(mode, px, py)) begin
        lat = k + 1; pf = 1'b0; break;
      end
      if (tries < mt) begin
        tries++; v = lfsr_step(v); k += 1;
      end else begin
        lat = k + 1; pf = 1'b1; break;
      end
    end
  endfunction

  task automatic mon(input int w, input bit v, input bit b, input int x, input int y, input bit f,
                     input int px, input int py, input int xmax, input int ymax, inout bit pv);
    exp_t e;
    bit have;
    have = 1'b0;
    if (w == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
    if (w == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
    if (pv) chk("busy_after_valid", b, 0);
    pv = v;
    if (have && cyc == e.chk_cyc) begin
      chk("probe_x", px, e.x);
      chk("probe_y", py, e.y);
    end
    if (v) begin
      total++;
      if (!have) begin
        bad++;
        $display("FAIL unexpected_valid dut%0d: got valid=1 expected no valid at cycle %0d", w, cyc);
      end else begin
        chk("valid_cycle", cyc, e.v_cyc);
        chk("x_out", x, e.x);
        chk("y_out", y, e.y);
        chk("fail", f, e.f);
        chk("busy_with_valid", b, 1);
        chk("x_in_range", x < xmax, 1);
        chk("y_in_range", y < ymax, 1);
        if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end else if (have && cyc > e.v_cyc) begin
      total++; bad++;
      $display("FAIL missing_valid dut%0d: got valid=0 expected valid at cycle %0d", w, e.v_cyc);
      if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  initial begin
    bit pv0, pv1;
    pv0 = 1'b0; pv1 = 1'b0;
    forever begin
      @(negedge Clk);
      if (reset) begin
        pv0 = 1'b0; pv1 = 1'b0;
      end else begin
        chk("lfsr_model0", lfsr_state0, m_lfsr);
        chk("lfsr_model1", lfsr_state1, m_lfsr);
        mon(0, valid0, busy0, int'(x_out0), int'(y_out0), fail0, int'(probe_x0), int'(probe_y0), 40, 30, pv0);
        mon(1, valid1, busy1, int'(x_out1), int'(y_out1), fail1, int'(probe_x1), int'(probe_y1), 1024, 1024, pv1);
      end
    end
  end

  task automatic draw(input int w, input int mode, input bit noise, input int exp_lat);
    exp_t e;
    int lat, px, py, e0, early;
    bit pf, r, vv;
    if (w == 0) begin
      occ_mode0 = mode;
      predict(m_lfsr, 40, 30, 6, 5, 15, mode, lat, px, py, pf);
      req0 = 1'b1;
    end else begin
      occ_mode1 = mode;
      predict(m_lfsr, 1024, 1024, 10, 10, 3, mode, lat, px, py, pf);
      req1 = 1'b1;
    end
    e0 = cyc + 1;
    e.v_cyc = e0 + lat; e.chk_cyc = e0 + lat - 1; e.x = px; e.y = py; e.f = pf;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
    early = 0;
    for (int j = 1; j <= lat + 2; j++) begin
      @(negedge Clk);
      r = noise && (j <= lat + 1) && ($urandom_range(0, 1) == 1);
      if (w == 0) req0 = r; else req1 = r;
      if (exp_lat > 0) begin
        vv = (w == 0) ? valid0 : valid1;
        if (j <= exp_lat && vv) early++;
        if (j == exp_lat + 1) chk("valid_at_fixed_latency", vv, 1);
        if (j == exp_lat + 2) chk("busy_low_after_done", (w == 0) ? busy0 : busy1, 0);
      end
    end
    if (exp_lat > 0) chk("no_early_valid", early, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int ret, zero_seen, mode;
    tbl[0] = '{1'b0, 10'h00F}; tbl[1] = '{1'b0, 10'h01E};
    tbl[2] = '{1'b0, 10'h03C}; tbl[3] = '{1'b0, 10'h078};
    tbl[4] = '{1'b0, 10'h0F1}; tbl[5] = '{1'b0, 10'h1E3};
    tbl[6] = '{1'b0, 10'h3C7}; tbl[7] = '{1'b0, 10'h38E};

    repeat (3) @(negedge Clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_x_out", x_out0, 0);
    chk("rst_y_out", y_out0, 0);
    chk("rst_probe_x", probe_x0, 0);
    chk("rst_probe_y", probe_y0, 0);

    for (int i = 0; i < 8; i++) begin
      seed_in = tbl[i].seed;
      chk($sformatf("lfsr_seq[%0d]", i), lfsr_state0, tbl[i].lfsr);
      @(negedge Clk);
    end
    seed_in = 1'b0;

    ret = 0; zero_seen = 0;
    for (int n = 8; n <= 1023; n++) begin
      if (lfsr_state0 == 10'd0) zero_seen = 1;
      if (lfsr_state0 == SEED && ret == 0) ret = n;
      @(negedge Clk);
    end
    chk("lfsr_period", ret, 1023);
    chk("lfsr_never_zero", zero_seen, 0);

    for (int i = 0; i < 200; i++) begin
      mode = (i % 25 == 3) ? 1 : ((i % 2 == 1) ? 2 : 0);
      draw(0, mode, (i % 3) != 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    draw(1, 0, 1'b0, 2 * SH + 1);
    for (int i = 0; i < 4; i++) draw(1, 2, 1'b1, 0);
    draw(1, 1, 1'b0, 4 * (2 * SH + 1));

    // Abort a draw in SHIFT_Y; nothing may come back for it.
    req1 = 1'b1;
    @(negedge Clk);
    req1 = 1'b0;
    repeat (SH + 3) @(negedge Clk);
    chk("busy_mid_draw", busy1, 1);
    #1 reset = 1'b1;
    q1.delete();
    repeat (2) @(negedge Clk);
    #1 reset = 1'b0;
    #1;
    chk("rel_lfsr0", lfsr_state0, SEED);
    chk("rel_lfsr1", lfsr_state1, SEED);
    chk("rel_busy", busy1, 0);
    chk("rel_valid", valid1, 0);
    chk("rel_fail", fail1, 0);
    chk("rel_x_out", x_out1, 0);
    chk("rel_y_out", y_out1, 0);
    chk("rel_probe_x", probe_x1, 0);
    chk("rel_probe_y", probe_y1, 0);
    repeat (100) @(negedge Clk);
    chk("idle_busy", busy1, 0);
    chk("idle_fail", fail1, 0);
    chk("idle_x_out", x_out1, 0);
    chk("idle_y_out", y_out1, 0);

    repeat (3) @(negedge Clk);
    chk("sb_empty0", q0.size(), 0);
    chk("sb_empty1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lfsr_coord_gen.md
# lfsr_coord_gen

Parametrised pseudo-random grid-coordinate generator for food and power-up placement in the Cobra Combat playfield. A free-running Fibonacci LFSR of configurable width and taps feeds a draw state machine. The state machine rejection-samples an (x, y) pair inside the playfield bounds, probes the game-board occupancy logic, and retries until it finds a free cell or exhausts its retry budget. A req/busy/valid handshake returns the result to the game controller.

## Interface
- WIDTH, 10: LFSR width in bits (≥ 4).
- TAPS, 10'h240: feedback tap mask; bit i set means state[i] enters the XOR (default is taps at bits 9 and 6).
- RESET_SEED, 10'h00F: LFSR reset value and lockup-recovery value; must be nonzero.
- X_MAX, 40: x range is [0, X_MAX); XW = $clog2(X_MAX); X_MAX ≤ 2^WIDTH.
- Y_MAX, 30: y range is [0, Y_MAX); YW = $clog2(Y_MAX); Y_MAX ≤ 2^WIDTH.
- SHIFTS, 10: LFSR steps between consecutive samples (≥ 1).
- MAX_TRIES, 15: occupancy retries allowed before giving up.
- Clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- seed_in, in, 1: external entropy bit; used only with LFSR_SEED_MIX_EN.
- req, in, 1: draw request; sampled only in IDLE.
- busy, out, 1: draw in progress.
- valid, out, 1: one-cycle pulse; x_out, y_out and fail are valid in this cycle.
- x_out, out, XW: drawn x; held until the next valid.
- y_out, out, YW: drawn y; held until the next valid.
- fail, out, 1: with valid, retries were exhausted and the returned cell is occupied.
- probe_x, out, XW: candidate x, driven in CHECK.
- probe_y, out, YW: candidate y, driven in CHECK.
- probe_occupied, in, 1: combinational reply from the board to probe_x/probe_y; sampled in CHECK only.
- lfsr_state, out, WIDTH: current LFSR register, exposed for debug.

## Operation
- **LFSR:** steps every cycle in every state.
  - fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}.
  - If next would be all-zero, load RESET_SEED instead.
- **States:**
  - IDLE: if req, go to SHIFT_X with cnt=0, tries=0, busy=1. Otherwise stay.
  - SHIFT_X: cnt increments each cycle. When cnt==SHIFTS-1, capture cx = lfsr_state[XW-1:0].
    - If cx < X_MAX, go to SHIFT_Y with cnt=0.
    - Otherwise stay in SHIFT_X with cnt=0 (rejection). Rejections do not count as tries.
  - SHIFT_Y: same rule with cy = lfsr_state[YW-1:0] against Y_MAX; on accept go to CHECK.
  - CHECK: probe_x=cx and probe_y=cy for one cycle. Then:
    - If !probe_occupied, go to DONE with fail=0.
    - If occupied and tries<MAX_TRIES, increment tries and go to SHIFT_X with cnt=0.
    - If occupied and tries==MAX_TRIES, go to DONE with fail=1.
  - DONE: valid=1, x_out=cx, y_out=cy, busy=0 on exit. Always return to IDLE.
- **Handshake:**
  - req is ignored outside IDLE; no queuing.
  - Back-to-back req is accepted in the IDLE cycle following DONE.
- **Comparisons:** candidate compares are unsigned, XW/YW bits wide. Candidate bits come from the LSBs of lfsr_state.
- **Reset values:** lfsr_state=RESET_SEED, state=IDLE, and busy, valid, fail, x_out, y_out, probe_x, probe_y, cnt, tries all 0.
- **Reset mid-draw:** abort immediately; no valid is emitted for the aborted request.

## Timing
- Call the edge at which IDLE samples req E0. Then:
  - SHIFT_Y is entered at E0+SHIFTS (no rejection).
  - CHECK is entered at E0+2·SHIFTS.
  - valid rises at E0+2·SHIFTS+1 (21 cycles with defaults), lasts 1 cycle, and IDLE follows.
- Each x or y rejection adds SHIFTS cycles. Each occupied retry adds 2·SHIFTS+1 cycles (minimum).
- busy is high from E0 to the end of the DONE cycle. valid and busy are both high in the DONE cycle.
- probe_occupied must settle combinationally within the CHECK cycle. probe_x/probe_y are stable for the whole cycle.

## Configuration
- LFSR_SEED_MIX_EN defined: fb = ^(state & TAPS) ^ seed_in. The sequence depends on seed_in history. The zero-state override still applies.
- Not defined: seed_in is unused. The sequence is fully deterministic from RESET_SEED, with period 2^WIDTH−1 for primitive TAPS.

## Test plan
- Reset, then seed_in=0: lfsr_state is 0x00F, then 0x01E, then 0x03C on successive cycles. With the macro off, the state returns to 0x00F after exactly 1023 steps and never reaches 0.
- X_MAX=Y_MAX=1024, SHIFTS=10, probe_occupied=0, req pulse at E0: valid exactly at E0+21, fail=0, x_out/y_out equal to the model's LFSR LSBs at the sample cycles, busy low the cycle after.
- Default bounds, 200 draws, probe_occupied=0: every x_out<40 and y_out<30. Latencies match the model including rejection cycles. req pulses while busy produce no extra valid.
- probe_occupied tied to 1, MAX_TRIES=3: exactly 4 CHECK cycles, then valid with fail=1 and x_out/y_out equal to the last probe.
- Assert reset during SHIFT_Y, release, wait 100 cycles without req: no valid, all outputs at reset values, lfsr_state=0x00F right after release.
- With LFSR_SEED_MIX_EN: force state 0 via the seed pattern. Next state is RESET_SEED when seed_in=0, and 0x001 when seed_in=1.
